// File: rtl/csa_accum_ctrl.sv
// Operand-stream accumulator: 3:2 carry-save accumulation followed by an
// iterative carry-resolve phase, with valid/ready handshakes on both sides.
module csa_accum_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_W-1:0]         num_ops,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     busy,
    output logic                     out_valid,
    output logic [WIDTH+CNT_W-1:0]   out_sum,
    input  logic                     out_ready
);

    localparam int ACC_W = WIDTH + CNT_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] s_vec;
    logic [ACC_W-1:0] c_vec;
    logic [CNT_W-1:0] remaining;
    logic [ACC_W-1:0] x_ext;
    logic             accept;

    function automatic logic [ACC_W-1:0] csa_sum(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b,
                                                 input logic [ACC_W-1:0] x);
        return a ^ b ^ x;
    endfunction

    // Majority bits shift into the next column; the top carry falls off the
    // ACC_W boundary, which is safe because the true sum always fits.
    function automatic logic [ACC_W-1:0] csa_carry(input logic [ACC_W-1:0] a,
                                                   input logic [ACC_W-1:0] b,
                                                   input logic [ACC_W-1:0] x);
        logic [ACC_W-1:0] maj;
        maj = (a & b) | (a & x) | (b & x);
        return maj << 1;
    endfunction

    assign x_ext  = {{CNT_W{1'b0}}, in_data};
    assign accept = (state == ACCUM) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_ops != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (in_valid && (remaining == CNT_W'(1))) begin
                    state_nxt = RESOLVE;
                end
            end
            RESOLVE: begin
                if (c_vec == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_vec     <= '0;
            c_vec     <= '0;
            remaining <= '0;
            out_sum   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= num_ops;
                        s_vec     <= '0;
                        c_vec     <= '0;
                        if (num_ops == '0) begin
                            out_sum <= '0;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        s_vec     <= csa_sum(s_vec, c_vec, x_ext);
                        c_vec     <= csa_carry(s_vec, c_vec, x_ext);
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                RESOLVE: begin
                    // Half-adder ripple step: each pass pushes carries one column up.
                    if (c_vec == '0) begin
                        out_sum <= s_vec;
                    end else begin
                        s_vec <= s_vec ^ c_vec;
                        c_vec <= (s_vec & c_vec) << 1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Randomized and directed bench for csa_accum_ctrl; the reference result of
// each transaction is the plain integer sum of the operands offered.
module tb_csa_accum_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
    localparam int ACC_W = WIDTH + CNT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_ops;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             busy;
    logic             out_valid;
    logic [ACC_W-1:0] out_sum;
    logic             out_ready;

    int checks   = 0;
    int failures = 0;
    int ops[16];
    int gaps[16];

    csa_accum_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_ops  (num_ops),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .out_valid(out_valid),
        .out_sum  (out_sum),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. poke drives stray start pulses
    // while busy and on the result handshake; they must all be ignored.
    task automatic txn(input int n, input int hold, input bit poke);
        int  exp_sum;
        int  acc;
        int  cyc;
        int  gap;
        int  r;
        bit  take;
        exp_sum = 0;
        for (int i = 0; i < n; i++) exp_sum += ops[i];
        acc = 0; cyc = 0; gap = 0;

        start = 1'b1;
        num_ops = n[CNT_W-1:0];
        @(negedge clk);
        start = 1'b0;
        check_val("busy_after_start", busy, 1);
        if (n == 0) begin
            check_val("zero_out_valid", out_valid, 1);
            check_val("zero_in_ready", in_ready, 0);
        end else begin
            check_val("in_ready_latency", in_ready, 1);
        end

        while (acc < n && cyc < 300) begin
            if (gap > 0) begin
                in_valid = 1'b0;
                gap--;
            end else begin
                in_valid = 1'b1;
                in_data  = ops[acc][WIDTH-1:0];
            end
            if (poke) begin
                start   = 1'b1;
                num_ops = CNT_W'($urandom);
            end
            take = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (take) begin
                gap = gaps[acc];
                acc++;
            end
        end
        check_val("operands_consumed", acc, n);

        if (n != 0) begin
            // Offer junk while resolving: none of it may be taken.
            r = 0;
            in_valid = 1'b1;
            in_data  = WIDTH'($urandom);
            check_val("in_ready_after_last", in_ready, 0);
            while (!out_valid && r < ACC_W + 3) begin
                if (in_ready) check_val("in_ready_in_resolve", in_ready, 0);
                start = poke;
                @(negedge clk);
                start = 1'b0;
                r++;
            end
            check_val("resolve_cycles_ok", (r >= 1 && r <= ACC_W + 1), 1);
        end
        in_valid = 1'b0;

        check_val("out_valid", out_valid, 1);
        check_val("out_sum", out_sum, exp_sum);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            start = poke;
            @(negedge clk);
            start = 1'b0;
            check_val("hold_valid", out_valid, 1);
            check_val("hold_sum", out_sum, exp_sum);
        end
        out_ready = 1'b1;
        start = poke;
        num_ops = 4'd5;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        check_val("post_hs_valid", out_valid, 0);
        check_val("post_hs_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; num_ops = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_sum", out_sum, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_busy", busy, 0);

        // 5+7+9, back-to-back
        ops[0] = 5; ops[1] = 7; ops[2] = 9;
        for (int i = 0; i < 16; i++) gaps[i] = 0;
        txn(3, 0, 0);
        check_val("sum_21_seen", 21, ops[0] + ops[1] + ops[2]);

        // 15 x 0xF
        for (int i = 0; i < 16; i++) ops[i] = 15;
        txn(15, 0, 0);

        // zero operands
        txn(0, 1, 0);

        // gaps 0/2/1 and consumer back-pressure
        ops[0] = 1; ops[1] = 2; ops[2] = 3; ops[3] = 4;
        gaps[0] = 0; gaps[1] = 2; gaps[2] = 1; gaps[3] = 0;
        txn(4, 5, 0);

        // async reset in the middle of accumulation
        for (int i = 0; i < 16; i++) gaps[i] = 0;
        start = 1'b1; num_ops = 4'd5;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_data = 4'd9;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("async_in_ready", in_ready, 0);
        check_val("async_busy", busy, 0);
        check_val("async_out_valid", out_valid, 0);
        check_val("async_out_sum", out_sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ops[0] = 3; ops[1] = 3;
        txn(2, 0, 0);

        // stray starts while busy and on the handshake
        ops[0] = 8; ops[1] = 6; ops[2] = 11;
        gaps[0] = 1; gaps[1] = 0; gaps[2] = 0;
        txn(3, 2, 1);

        for (int t = 0; t < 25; t++) begin
            int n;
            n = $urandom_range(15, 0);
            for (int i = 0; i < 16; i++) begin
                ops[i]  = $urandom_range(15, 0);
                gaps[i] = $urandom_range(2, 0);
            end
            txn(n, $urandom_range(3, 0), 1'($urandom));
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
